// File: rtl/cipher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cipher_pkg: shared widths, FSM encoding and FIFO default depth     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cipher_pkg;
  localparam int BYTE_W              = 8;
  localparam int CNT_W               = $clog2(BYTE_W);
  localparam int KFIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/key_byte_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_byte_fifo: synchronous key-byte FIFO, flushable, push+pop full |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module key_byte_fifo
  import cipher_pkg::*;
#(
  parameter int DEPTH = KFIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_pop;
  logic              w_do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule
`default_nettype wire

// File: rtl/stream_xor_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_xor_engine: packs keystream bits into bytes, XORs data      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stream_xor_engine
  import cipher_pkg::*;
#(
  parameter int KFIFO_DEPTH = KFIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ks_rst,
  input  logic              keystream,
  input  logic              msg_start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);
  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_next;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_overrun;
  logic              w_run;
  logic              w_flush;
  logic              w_push;
  logic              w_hs;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [BYTE_W-1:0] w_key_head;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (msg_start) w_state_next = SYNC;
        SYNC:    w_state_next = RUN;
        RUN:     if (msg_start) w_state_next = SYNC;
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign w_run        = (r_state == RUN);
  assign w_flush      = abort | (r_state == SYNC);
  assign ks_rst       = rst | (r_state == SYNC);
  assign busy         = (r_state == SYNC) | (r_state == RUN);
  // Right shift lands the first sampled bit in bit 0 after eight samples.
  assign w_shift_next = {keystream, r_shift[BYTE_W-1:1]};
  assign w_push       = w_run & ~abort & (r_bit_cnt == CNT_W'(BYTE_W - 1));
  assign in_ready     = w_run & ~w_fifo_empty & (~r_out_valid | out_ready);
  assign w_hs         = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_run) begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      r_shift   <= w_shift_next;
    end
  end

  key_byte_fifo #(
    .DEPTH (KFIFO_DEPTH)
  ) u_kfifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_shift_next),
    .i_pop   (w_hs),
    .o_head  (w_key_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_hs) begin
      r_out_data  <= in_data ^ w_key_head;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // A key byte is lost only when the FIFO is full and nothing leaves it.
  always_ff @(posedge clk) begin
    if (rst || (r_state == SYNC)) r_overrun <= 1'b0;
    else if (w_push && w_fifo_full && !w_hs) r_overrun <= 1'b1;
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_stream_xor_engine.sv
`default_nettype none
// Bench for stream_xor_engine: behavioural model + scoreboard, directed
// scenarios followed by randomized traffic.
module tb_stream_xor_engine;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, ks_rst, keystream, msg_start, abort;
  logic       in_valid, in_ready, out_valid, out_ready, overrun, busy;
  logic [7:0] in_data, out_data;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  stream_xor_engine #(.KFIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .ks_rst    (ks_rst),
    .keystream (keystream),
    .msg_start (msg_start),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=sync 2=run; key bytes kept as a queue.
  int         m_mode  = 0;
  int         m_nbits = 0;
  logic [7:0] m_acc   = 8'h00;
  logic [7:0] m_keys[$];
  logic [7:0] m_exp[$];
  bit         m_outv  = 1'b0;
  bit         m_ovr   = 1'b0;

  function bit model_ready();
    return (m_mode == 2) && (m_keys.size() > 0) && (!m_outv || out_ready);
  endfunction

  function void model_flush();
    m_keys.delete();
    m_exp.delete();
    m_nbits = 0;
    m_acc   = 8'h00;
    m_outv  = 1'b0;
  endfunction

  always @(posedge clk) begin
    bit         hs;
    logic [7:0] key;
    if (rst) begin
      m_mode = 0;
      model_flush();
      m_ovr  = 1'b0;
    end else begin
      hs = in_valid && model_ready();
      if (m_mode == 1) m_ovr = 1'b0;
      if (abort) begin
        m_mode = 0;
        model_flush();
      end else if (m_mode == 1) begin
        m_mode = 2;
        model_flush();
      end else if (m_mode == 0) begin
        if (msg_start) m_mode = 1;
      end else begin
        if (hs) begin
          key = m_keys.pop_front();
          m_exp.push_back(in_data ^ key);
          m_outv = 1'b1;
        end else if (out_ready) begin
          m_outv = 1'b0;
        end
        m_acc[m_nbits] = keystream;
        m_nbits++;
        if (m_nbits == 8) begin
          if (m_keys.size() < D) m_keys.push_back(m_acc);
          else                   m_ovr = 1'b1;
          m_nbits = 0;
          m_acc   = 8'h00;
        end
        if (msg_start) m_mode = 1;
      end
    end
  end

  // Monitor: compares DUT against the model mid-cycle and drains the scoreboard.
  always @(negedge clk) begin
    check("ks_rst", ks_rst, rst | (m_mode == 1));
    if (!rst) begin
      check("busy", busy, m_mode != 0);
      check("in_ready", in_ready, model_ready());
      check("out_valid", out_valid, m_outv);
      check("overrun", overrun, m_ovr);
      if (out_valid) begin
        check("sb_nonempty", m_exp.size() > 0, 1);
        if (m_exp.size() > 0) begin
          check("out_data", out_data, m_exp[0]);
          if (out_ready) void'(m_exp.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg();
    msg_start = 1'b1;
    tick();
    msg_start = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] pat, input logic [7:0] din, input logic [7:0] dout);
    start_msg();
    keystream = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      keystream = pat[k];
      if (k == 7) begin
        @(negedge clk);
        check("ready_before_key", in_ready, 0);
      end
      tick();
    end
    keystream = 1'b0;
    in_data   = din;
    in_valid  = 1'b1;
    @(negedge clk);
    check("first_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("enc_valid", out_valid, 1);
    check("enc_data", out_data, dout);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1; msg_start = 1'b0; abort = 1'b0; keystream = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_ks_rst", ks_rst, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    run_one(8'h4D, 8'hAB, 8'hE6);
    run_one(8'h4D, 8'hE6, 8'hAB);

    // Backpressure with a second key byte queued.
    start_msg();
    for (int i = 0; i < 17; i++) begin
      keystream = 1'($urandom);
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    tick();
    in_data = 8'($urandom);
    @(negedge clk);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      keystream = 1'($urandom);
      @(negedge clk);
      check("bp_stable", out_data, held);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", out_valid, 1);
    tick();

    // Overrun: no consumption, fifth push is dropped.
    start_msg();
    for (int i = 0; i < 40; i++) begin
      keystream = 1'($urandom);
      tick();
    end
    @(negedge clk);
    check("ovr_before", overrun, 0);
    tick();
    @(negedge clk);
    check("ovr_set", overrun, 1);
    for (int i = 0; i < 8; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("ovr_after_abort", overrun, 1);
    check("abort_idle", busy, 0);
    start_msg();
    @(negedge clk);
    check("ovr_in_sync", overrun, 1);
    tick();
    @(negedge clk);
    check("ovr_cleared", overrun, 0);

    // Restart mid-message: 3 bytes queued, 5 bits collected.
    for (int i = 0; i < 29; i++) begin
      keystream = 1'($urandom);
      tick();
    end
    start_msg();
    @(negedge clk);
    check("restart_ks_rst", ks_rst, 1);
    check("restart_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("restart_ks_rst_end", ks_rst, 0);
    for (int i = 0; i < 7; i++) begin
      keystream = 1'($urandom);
      tick();
    end
    @(negedge clk);
    check("restart_empty_e8", in_ready, 0);
    tick();
    @(negedge clk);
    check("restart_push_e9", in_ready, 1);

    // Randomized traffic.
    for (int i = 0; i < 1200; i++) begin
      keystream = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      msg_start = ($urandom_range(0, 149) == 0) || (i == 0);
      abort     = ($urandom_range(0, 199) == 0);
      tick();
    end
    msg_start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
